// File: rtl/instr_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the core in reset until done.
module instr_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             we,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             cpu_rst,
    output logic             done,
    output logic             err
);

    localparam int          CW      = ADDR_WIDTH + 1;
    localparam logic [16:0] DEPTH_C = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t          state_r;
    logic [15:0]     n_r;
    logic [CW-1:0]   word_idx_r;
    logic [1:0]      byte_cnt_r;
    logic [23:0]     word_r;

    logic            xfer_s;
    logic [15:0]     hdr_n_s;
    logic            too_long_s;
    logic            last_word_s;

    assign xfer_s      = byte_valid && byte_ready;
    assign hdr_n_s     = {byte_in, n_r[7:0]};
    assign too_long_s  = ({1'b0, hdr_n_s} > DEPTH_C);
    // word_idx is one bit wider than the address so N == DEPTH terminates cleanly
    assign last_word_s = ((16'(word_idx_r) + 16'd1) == n_r);

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            n_r        <= 16'h0000;
            word_idx_r <= {CW{1'b0}};
            byte_cnt_r <= 2'd0;
            word_r     <= 24'h000000;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            waddr      <= {WIDTH{1'b0}};
            wdata      <= {WIDTH{1'b0}};
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r    <= S_HDR_LO;
                        byte_ready <= 1'b1;
                    end
                end
                S_HDR_LO: begin
                    if (xfer_s) begin
                        n_r[7:0] <= byte_in;
                        state_r  <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (xfer_s) begin
                        n_r[15:8] <= byte_in;
                        if (hdr_n_s == 16'h0000) begin
                            state_r    <= S_DONE;
                            byte_ready <= 1'b0;
                            done       <= 1'b1;
                            cpu_rst    <= 1'b0;
                        end else if (too_long_s) begin
                            state_r    <= S_ERR;
                            byte_ready <= 1'b0;
                            err        <= 1'b1;
                        end else begin
                            state_r    <= S_DATA;
                            word_idx_r <= {CW{1'b0}};
                            byte_cnt_r <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: word_r[7:0]   <= byte_in;
                            2'd1: word_r[15:8]  <= byte_in;
                            2'd2: word_r[23:16] <= byte_in;
                            default: begin
                                state_r    <= S_WRITE;
                                byte_ready <= 1'b0;
                                we         <= 1'b1;
                                wdata      <= {byte_in, word_r};
                                waddr      <= {{(WIDTH-ADDR_WIDTH-2){1'b0}},
                                               word_idx_r[ADDR_WIDTH-1:0], 2'b00};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_idx_r <= word_idx_r + {{(CW-1){1'b0}}, 1'b1};
                    if (last_word_s) begin
                        state_r <= S_DONE;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state_r    <= S_DATA;
                        byte_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_r    <= S_HDR_LO;
                        byte_ready <= 1'b1;
                        done       <= 1'b0;
                        cpu_rst    <= 1'b1;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        state_r    <= S_HDR_LO;
                        byte_ready <= 1'b1;
                        err        <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_rst    <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader: two-word loads, backpressure,
// edge lengths, reset abort and restart behaviour.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int rdy_viol = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    instr_loader #(.WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .we(we),
        .waddr(waddr), .wdata(wdata), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Log every write pulse seen mid-cycle
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
            if (byte_ready !== 1'b0) rdy_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte at a negedge, hold it until accepted, return at the next negedge
    task automatic send(input logic [7:0] b, input int max_gap);
        int n = 0;
        byte_valid = 1'b0;
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [7:0] two_word [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                                  8'h93, 8'h05, 8'h20, 8'h00};

    initial begin
        int base;
        logic [7:0] i8;
        rst = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            start      = 1'($urandom_range(0, 1));
            byte_valid = 1'($urandom_range(0, 1));
            byte_in    = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_waddr", waddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        start = 1'b0; byte_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // Two-word load, no stalls
        base = wa_q.size();
        pulse_start();
        chk("start_ready", 32'(byte_ready), 32'd1);
        for (int i = 0; i < 10; i++) send(two_word[i], 0);
        chk("last_write_we", 32'(we), 32'd1);
        chk("last_write_ready", 32'(byte_ready), 32'd0);
        chk("last_write_cpu_rst", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        chk("done_after_write", 32'(done), 32'd1);
        chk("cpu_rst_released", 32'(cpu_rst), 32'd0);
        chk("two_count", 32'(wa_q.size() - base), 32'd2);
        chk("two_wa0", wa_q[base], 32'h0);
        chk("two_wd0", wd_q[base], 32'h00100513);
        chk("two_wa1", wa_q[base+1], 32'h4);
        chk("two_wd1", wd_q[base+1], 32'h00200593);
        chk("hold_waddr", waddr, 32'h4);
        chk("hold_wdata", wdata, 32'h00200593);

        // Restart from DONE, backpressured reload, start during DATA ignored
        pulse_start();
        chk("restart_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        base = wa_q.size();
        for (int i = 0; i < 10; i++) begin
            send(two_word[i], 2);
            if (i == 3) pulse_start();
        end
        repeat (3) @(negedge clk);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_count", 32'(wa_q.size() - base), 32'd2);
        chk("bp_wa0", wa_q[base], 32'h0);
        chk("bp_wd0", wd_q[base], 32'h00100513);
        chk("bp_wa1", wa_q[base+1], 32'h4);
        chk("bp_wd1", wd_q[base+1], 32'h00200593);
        chk("ready_in_write", 32'(rdy_viol), 32'd0);

        // Zero-length program
        pulse_start();
        base = wa_q.size();
        send(8'h00, 0);
        send(8'h00, 0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_cpu_rst", 32'(cpu_rst), 32'd0);
        repeat (2) @(negedge clk);
        chk("zero_no_we", 32'(wa_q.size() - base), 32'd0);

        // N = DEPTH+1 rejected
        pulse_start();
        send(8'h01, 0);
        send(8'h01, 0);
        chk("long_err", 32'(err), 32'd1);
        chk("long_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("long_ready", 32'(byte_ready), 32'd0);
        chk("long_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        chk("long_no_we", 32'(wa_q.size() - base), 32'd0);

        // N = DEPTH fills the whole memory
        pulse_start();
        chk("err_cleared", 32'(err), 32'd0);
        base = wa_q.size();
        send(8'h00, 0);
        send(8'h01, 0);
        for (int i = 0; i < 256; i++) begin
            i8 = 8'(i);
            send(i8, 0);
            send(8'h5A, 0);
            send(~i8, 0);
            send(8'hC3, 0);
        end
        repeat (2) @(negedge clk);
        chk("full_done", 32'(done), 32'd1);
        chk("full_count", 32'(wa_q.size() - base), 32'd256);
        chk("full_wa0", wa_q[base], 32'h0);
        chk("full_wd0", wd_q[base], 32'hC3FF5A00);
        chk("full_wa255", wa_q[base+255], 32'h3FC);
        chk("full_wd255", wd_q[base+255], 32'hC3005AFF);
        chk("full_wa100", wa_q[base+100], 32'h190);
        chk("full_wd100", wd_q[base+100], 32'hC39B5A64);

        // Reset mid-word aborts without a write
        pulse_start();
        base = wa_q.size();
        for (int i = 0; i < 4; i++) send(two_word[i], 0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(byte_ready), 32'd0);
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_we", 32'(wa_q.size() - base), 32'd0);
        pulse_start();
        for (int i = 0; i < 10; i++) send(two_word[i], 1);
        repeat (3) @(negedge clk);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_count", 32'(wa_q.size() - base), 32'd2);
        chk("reload_wa0", wa_q[base], 32'h0);
        chk("reload_wd0", wd_q[base], 32'h00100513);
        chk("reload_wd1", wd_q[base+1], 32'h00200593);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
